// File: rtl/i2s_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_pkg
// Brief    : Shared constants and types for the I2S transmitter.
// Revision : 1.0
// ============================================================================
package i2s_tx_pkg;

    // Sample/slot widths shared with the equalizer filter chain
    localparam int I2S_DATA_W  = 24;
    localparam int I2S_SLOT_W  = 32;
    localparam int I2S_FRAME_W = 2 * I2S_SLOT_W;
    localparam int I2S_CNT_W   = $clog2(I2S_FRAME_W);

    typedef enum logic [0:0] {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_chan_e;

    function automatic int frame_cnt_w(input int slot_w);
        return $clog2(2 * slot_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_bclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : i2s_bclk_gen
// Brief    : BCLK divider; emits a one-cycle strobe on each BCLK falling edge.
// Revision : 1.0
// ============================================================================
module i2s_bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_bclk,
    output logic o_fall_stb
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_bclk;
    logic             w_div_term;

    assign w_div_term = (r_div == C_DIV_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (w_div_term) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + DIV_W'(1);
        end
    end

    // High in the cycle whose closing edge takes BCLK from 1 to 0
    assign o_fall_stb = w_div_term & r_bclk;
    assign o_bclk     = r_bclk;

endmodule
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx
// Brief    : Philips I2S serialiser with one-entry sample-pair buffer.
//            Optional macro I2S_TX_HOLD_LAST_EN resends last frame on underrun.
// Revision : 1.0
// ============================================================================
module i2s_tx
    import i2s_tx_pkg::*;
#(
    parameter int DATA_W   = I2S_DATA_W,
    parameter int SLOT_W   = I2S_SLOT_W,
    parameter int BCLK_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data_l,
    input  logic [DATA_W-1:0] i_data_r,
    output logic              o_ready,
    output logic              o_bclk,
    output logic              o_lrclk,
    output logic              o_sdata,
    output logic              o_underrun
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int CNT_W   = frame_cnt_w(SLOT_W);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] C_CNT_SLOT = CNT_W'(SLOT_W);

    logic               w_fall_stb;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_frame_start;
    logic [FRAME_W-1:0] r_shreg;
    logic [FRAME_W-1:0] w_buf_word;
    logic [FRAME_W-1:0] w_fill_word;
    logic               r_full;
    logic [DATA_W-1:0]  r_buf_l;
    logic [DATA_W-1:0]  r_buf_r;
    i2s_chan_e          r_lrclk;
    i2s_chan_e          w_chan_next;
    logic               r_sdata;
    logic               r_underrun;
    logic               w_accept;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .o_bclk     (o_bclk),
        .o_fall_stb (w_fall_stb)
    );

    assign w_cnt_next    = (r_bit_cnt == C_CNT_LAST) ? '0 : r_bit_cnt + CNT_W'(1);
    assign w_frame_start = (w_cnt_next == '0);
    assign w_chan_next   = (w_cnt_next >= C_CNT_SLOT) ? CH_RIGHT : CH_LEFT;
    assign w_accept      = i_valid & ~r_full;

    // Samples are left-justified in their slots with zero pad below the LSB
    assign w_buf_word = (FRAME_W'(r_buf_l) << (FRAME_W - DATA_W))
                      | (FRAME_W'(r_buf_r) << (SLOT_W - DATA_W));

`ifdef I2S_TX_HOLD_LAST_EN
    logic [FRAME_W-1:0] r_last_word;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_word <= '0;
        end else if (w_fall_stb && w_frame_start && r_full) begin
            r_last_word <= w_buf_word;
        end
    end

    assign w_fill_word = r_last_word;
`else
    assign w_fill_word = '0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt  <= C_CNT_LAST;
            r_shreg    <= '0;
            r_lrclk    <= CH_LEFT;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
            r_full     <= 1'b0;
            r_buf_l    <= '0;
            r_buf_r    <= '0;
        end else begin
            r_underrun <= 1'b0;

            // The MSB of the shifter is always the next bit on the wire, so
            // on a load it still holds the previous frame's last bit: this
            // yields the one-BCLK I2S data delay without extra state.
            if (w_fall_stb) begin
                r_bit_cnt <= w_cnt_next;
                r_lrclk   <= w_chan_next;
                r_sdata   <= r_shreg[FRAME_W-1];
                if (w_frame_start) begin
                    if (r_full) begin
                        r_shreg <= w_buf_word;
                    end else begin
                        r_shreg    <= w_fill_word;
                        r_underrun <= 1'b1;
                    end
                end else begin
                    r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
                end
            end

            if (w_fall_stb && w_frame_start && r_full) begin
                r_full <= 1'b0;
            end else if (w_accept) begin
                r_full  <= 1'b1;
                r_buf_l <= i_data_l;
                r_buf_r <= i_data_r;
            end
        end
    end

    assign o_ready    = ~r_full;
    assign o_lrclk    = r_lrclk;
    assign o_sdata    = r_sdata;
    assign o_underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx
// Brief    : Directed self-checking bench for i2s_tx (BCLK_DIV=2).
// Revision : 1.0
// ============================================================================
module tb_i2s_tx;

    localparam int BCLK_DIV = 2;
    localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;
`ifdef I2S_TX_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        valid  = 1'b0;
    logic [23:0] data_l = '0;
    logic [23:0] data_r = '0;
    logic        ready, bclk, lrclk, sdata, underrun;

    i2s_tx #(
        .DATA_W   (24),
        .SLOT_W   (32),
        .BCLK_DIV (BCLK_DIV)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .i_data_l   (data_l),
        .i_data_r   (data_r),
        .o_ready    (ready),
        .o_bclk     (bclk),
        .o_lrclk    (lrclk),
        .o_sdata    (sdata),
        .o_underrun (underrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int mon_k = 63;
    int ur_cnt = 0;
    int acc_cnt = 0;
    int bclk_per = 0;
    int last_rise = 0;
    bit prev_bclk = 1'b0;
    logic [63:0] cur_frame = '0;
    logic [63:0] cur_lr = '0;
    logic [63:0] frames[$];
    logic [63:0] lrs[$];

    // Observer: rebuilds each frame from the wire, indexed by bit position
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_bclk = 1'b0;
            mon_k     = 63;
        end else begin
            if (bclk && !prev_bclk) begin
                bclk_per  = cyc - last_rise;
                last_rise = cyc;
            end
            if (prev_bclk && !bclk) begin
                mon_k = (mon_k + 1) % 64;
                cur_frame[63 - ((mon_k + 63) % 64)] = sdata;
                cur_lr[mon_k] = lrclk;
                if (mon_k == 63) begin
                    frames.push_back(cur_frame);
                    lrs.push_back(cur_lr);
                end
            end
            if (underrun) ur_cnt++;
            prev_bclk = bclk;
        end
    end

    always @(posedge clk) begin
        if (rst_n && valid && ready) acc_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] fw(input logic [23:0] l, input logic [23:0] r);
        return {l, 8'h00, r, 8'h00};
    endfunction

    function automatic logic [63:0] frame_at(input int i);
        return (i < frames.size()) ? frames[i] : 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    function automatic logic [63:0] lr_at(input int i);
        return (i < lrs.size()) ? lrs[i] : 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        repeat (2) tick();
        frames.delete();
        lrs.delete();
        ur_cnt  = 0;
        acc_cnt = 0;
        rst_n   = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (frames.size() < n && t < budget) begin
            tick();
            t++;
        end
        if (frames.size() < n) check("frame_timeout", 64'(frames.size()), 64'(n));
    endtask

    task automatic wait_k(input int k, input int budget);
        int t = 0;
        while (mon_k != k && t < budget) begin
            tick();
            t++;
        end
        if (mon_k != k) check("k_timeout", 64'(mon_k), 64'(k));
    endtask

    initial begin
        int first, second, ready_low, ur_at;

        // Idle: reset values, BCLK period, periodic underrun, silent frame
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_bclk", 64'(bclk), 64'd0);
        check("rst_lrclk", 64'(lrclk), 64'd0);
        check("rst_sdata", 64'(sdata), 64'd0);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_underrun", 64'(underrun), 64'd0);
        rst_n = 1'b1;
        first = -1; second = -1; ready_low = 0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (underrun) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            if (!ready) ready_low = 1;
        end
        check("idle_first_ur", 64'(first), 64'd4);
        check("idle_ur_period", 64'(second - first), 64'd256);
        check("idle_bclk_period", 64'(bclk_per), 64'd4);
        check("idle_ready_low", 64'(ready_low), 64'd0);
        check("idle_frame", frame_at(0), 64'd0);
        check("idle_lrclk", lr_at(0), LR_EXP);

        // Single pair before first frame; sign/extreme bit patterns
        do_reset();
        valid = 1'b1; data_l = 24'h800001; data_r = 24'h7FFFFE;
        tick();
        check("b_ready_busy", 64'(ready), 64'd0);
        valid = 1'b0; data_l = 24'h5A5A5A; data_r = 24'hA5A5A5;
        wait_frames(2, 700);
        check("b_frame0", frame_at(0), fw(24'h800001, 24'h7FFFFE));
        check("b_lrclk0", lr_at(0), LR_EXP);
        check("b_frame1", frame_at(1), HOLD ? fw(24'h800001, 24'h7FFFFE) : 64'd0);
        check("b_ur_cnt", 64'(ur_cnt), 64'd1);
        check("b_ready_free", 64'(ready), 64'd1);

        // Back-to-back with valid held high
        do_reset();
        valid = 1'b1;
        for (int c = 1; c <= 1026; c++) begin
            data_l = 24'(24'h100000 + acc_cnt);
            data_r = 24'(24'h200000 + acc_cnt);
            tick();
        end
        valid = 1'b0;
        check("c_accepts", 64'(acc_cnt), 64'd5);
        check("c_ur_cnt", 64'(ur_cnt), 64'd0);
        for (int i = 0; i < 4; i++)
            check("c_frame", frame_at(i), fw(24'(24'h100000 + i), 24'(24'h200000 + i)));

        // Accept coinciding with frame load on an empty buffer
        do_reset();
        repeat (3) tick();
        valid = 1'b1; data_l = 24'h0A0B0C; data_r = 24'hF0E0D0;
        tick();
        check("d_underrun", 64'(underrun), 64'd1);
        check("d_ready_busy", 64'(ready), 64'd0);
        valid = 1'b0;
        wait_frames(2, 700);
        check("d_frame0", frame_at(0), 64'd0);
        check("d_frame1", frame_at(1), fw(24'h0A0B0C, 24'hF0E0D0));

        // Buffer a pair, then reset mid-frame at bit 40
        wait_k(5, 100);
        valid = 1'b1; data_l = 24'h111111; data_r = 24'h222222;
        tick();
        valid = 1'b0;
        wait_k(40, 400);
        check("e_lrclk_pre", 64'(lrclk), 64'd1);
        check("e_ready_pre", 64'(ready), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        check("e_rst_bclk", 64'(bclk), 64'd0);
        check("e_rst_lrclk", 64'(lrclk), 64'd0);
        check("e_rst_sdata", 64'(sdata), 64'd0);
        check("e_rst_ready", 64'(ready), 64'd1);
        tick();
        frames.delete();
        lrs.delete();
        ur_cnt = 0;
        rst_n = 1'b1;
        ur_at = -1;
        for (int c = 1; c <= 20 && ur_at < 0; c++) begin
            tick();
            if (underrun) ur_at = c;
        end
        check("e_first_load", 64'(ur_at), 64'd4);
        wait_frames(1, 400);
        check("e_frame0", frame_at(0), 64'd0);

        // Starvation after one pair
        do_reset();
        valid = 1'b1; data_l = 24'h123456; data_r = 24'hABCDEF;
        tick();
        valid = 1'b0;
        wait_frames(2, 700);
        check("f_frame0", frame_at(0), fw(24'h123456, 24'hABCDEF));
        check("f_frame1", frame_at(1), HOLD ? fw(24'h123456, 24'hABCDEF) : 64'd0);
        check("f_ur_cnt", 64'(ur_cnt), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
